// File: rtl/qoi_pkg.sv
// Shared QOI definitions: op codes, pixel type, colour hash and op byte lengths.
package qoi_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] a;
    } pixel_t;

    localparam logic [7:0] QOI_OP_INDEX = 8'h00;
    localparam logic [7:0] QOI_OP_DIFF  = 8'h40;
    localparam logic [7:0] QOI_OP_LUMA  = 8'h80;
    localparam logic [7:0] QOI_OP_RUN   = 8'hC0;
    localparam logic [7:0] QOI_OP_RGB   = 8'hFE;
    localparam logic [7:0] QOI_OP_RGBA  = 8'hFF;
    localparam logic [7:0] QOI_MASK_2   = 8'hC0;

    localparam logic [2:0] LEN_RUN   = 3'd1;
    localparam logic [2:0] LEN_INDEX = 3'd1;
    localparam logic [2:0] LEN_DIFF  = 3'd1;
    localparam logic [2:0] LEN_LUMA  = 3'd2;
    localparam logic [2:0] LEN_RGB   = 3'd4;
    localparam logic [2:0] LEN_RGBA  = 3'd5;

    // Previous pixel at the start of every image.
    localparam pixel_t PIXEL_RESET = '{r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF};

    // Sum is formed at 13 bits so no product wraps before the modulo 64.
    function automatic logic [5:0] qoi_hash(input pixel_t p);
        return 6'(13'(p.r) * 13'd3 + 13'(p.g) * 13'd5 + 13'(p.b) * 13'd7 + 13'(p.a) * 13'd11);
    endfunction

endpackage

// File: rtl/qoi_index_table.sv
// 64-entry colour index: combinational read by hash, single write port, bulk clear.
module qoi_index_table
    import qoi_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic [5:0]  rd_hash,
    output logic [31:0] rd_pixel,
    input  logic        wr_en,
    input  logic [5:0]  wr_hash,
    input  logic [31:0] wr_pixel
);

    pixel_t entries [DEPTH];

    assign rd_pixel = entries[rd_hash];

    // Clear wins over a same-cycle write so the next image starts from an empty table.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_hash] <= pixel_t'(wr_pixel);
        end
    end

endmodule

// File: rtl/qoi_encoder_stream.sv
// Streaming QOI pixel encoder: one pixel in, at most one beat of 1..6 op bytes out.
module qoi_encoder_stream
    import qoi_pkg::*;
#(
    parameter int unsigned CHANNELS    = 3,
    parameter int unsigned INDEX_DEPTH = 64,
    parameter int unsigned MAX_RUN     = 62
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_r,
    input  logic [7:0]  in_g,
    input  logic [7:0]  in_b,
    input  logic [7:0]  in_a,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_data,
    output logic [2:0]  out_bytes,
    output logic        out_last
);

    if (INDEX_DEPTH != 64) begin : gen_bad_depth
        $error("qoi_encoder_stream: INDEX_DEPTH must be 64");
    end
    if (CHANNELS != 3 && CHANNELS != 4) begin : gen_bad_channels
        $error("qoi_encoder_stream: CHANNELS must be 3 or 4");
    end
    if (MAX_RUN < 1 || MAX_RUN > 62) begin : gen_bad_run
        $error("qoi_encoder_stream: MAX_RUN must be in 1..62");
    end

    localparam logic [5:0] MAX_RUN_W = 6'(MAX_RUN);

    pixel_t      px, prev_q, prev_d;
    logic [31:0] idx_pixel;
    logic [5:0]  px_hash;
    logic [5:0]  run_q, run_d, run_inc;
    logic        accept, is_same, run_flush, idx_hit, alpha_eq, diff_ok, luma_ok;
    logic [7:0]  dr, dg, db, dr_p2, dg_p2, db_p2, dg_p32, drdg_p8, dbdg_p8;
    logic [7:0]  run_byte_pend, run_byte_here;
    logic [39:0] op_field;
    logic [2:0]  op_len;
    logic        beat_en;
    logic [47:0] beat_data;
    logic [2:0]  beat_bytes;

    logic        out_valid_q, out_valid_d;
    logic [47:0] out_data_q, out_data_d;
    logic [2:0]  out_bytes_q, out_bytes_d;
    logic        out_last_q, out_last_d;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign px_hash  = qoi_hash(px);

    qoi_index_table #(
        .DEPTH (INDEX_DEPTH)
    ) u_index (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept && in_last),
        .rd_hash  (px_hash),
        .rd_pixel (idx_pixel),
        .wr_en    (accept),
        .wr_hash  (px_hash),
        .wr_pixel (px)
    );

    // Pixel assembly and channel deltas; biased compares replace signed range checks.
    always_comb begin
        px.r = in_r;
        px.g = in_g;
        px.b = in_b;
        px.a = (CHANNELS == 4) ? in_a : 8'hFF;

        dr      = px.r - prev_q.r;
        dg      = px.g - prev_q.g;
        db      = px.b - prev_q.b;
        dr_p2   = dr + 8'd2;
        dg_p2   = dg + 8'd2;
        db_p2   = db + 8'd2;
        dg_p32  = dg + 8'd32;
        drdg_p8 = dr - dg + 8'd8;
        dbdg_p8 = db - dg + 8'd8;

        alpha_eq = (px.a == prev_q.a);
        idx_hit  = (idx_pixel == px);
        diff_ok  = alpha_eq && (dr_p2 < 8'd4) && (dg_p2 < 8'd4) && (db_p2 < 8'd4);
        luma_ok  = alpha_eq && (dg_p32 < 8'd64) && (drdg_p8 < 8'd16) && (dbdg_p8 < 8'd16);
    end

    // Op selection in priority order INDEX, DIFF, LUMA, RGB, RGBA; bytes left-aligned.
    always_comb begin
        op_field = '0;
        op_len   = LEN_RGBA;
        if (idx_hit) begin
            op_field = {QOI_OP_INDEX | {2'b00, px_hash}, 32'h0};
            op_len   = LEN_INDEX;
        end else if (diff_ok) begin
            op_field = {QOI_OP_DIFF | {2'b00, dr_p2[1:0], dg_p2[1:0], db_p2[1:0]}, 32'h0};
            op_len   = LEN_DIFF;
        end else if (luma_ok) begin
            op_field = {QOI_OP_LUMA | {2'b00, dg_p32[5:0]}, drdg_p8[3:0], dbdg_p8[3:0], 24'h0};
            op_len   = LEN_LUMA;
        end else if (alpha_eq) begin
            op_field = {QOI_OP_RGB, px.r, px.g, px.b, 8'h0};
            op_len   = LEN_RGB;
        end else begin
            op_field = {QOI_OP_RGBA, px.r, px.g, px.b, px.a};
            op_len   = LEN_RGBA;
        end
    end

    // Run tracking and beat composition; a pending run rides in front of the op.
    always_comb begin
        is_same       = (px == prev_q);
        run_inc       = run_q + 6'd1;
        run_flush     = is_same && ((run_inc == MAX_RUN_W) || in_last);
        run_byte_pend = QOI_OP_RUN | ({2'b00, run_q - 6'd1} & ~QOI_MASK_2);
        run_byte_here = QOI_OP_RUN | ({2'b00, run_q} & ~QOI_MASK_2);

        beat_en    = 1'b1;
        beat_data  = {op_field, 8'h0};
        beat_bytes = op_len;
        if (is_same) begin
            beat_en    = run_flush;
            beat_data  = {run_byte_here, 40'h0};
            beat_bytes = LEN_RUN;
        end else if (run_q != 6'd0) begin
            beat_data  = {run_byte_pend, op_field};
            beat_bytes = op_len + LEN_RUN;
        end
    end

    // Encoder state and output register next-state.
    always_comb begin
        prev_d      = prev_q;
        run_d       = run_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_bytes_d = out_bytes_q;
        out_last_d  = out_last_q;

        if (accept) begin
            if (in_last) begin
                prev_d = PIXEL_RESET;
                run_d  = 6'd0;
            end else begin
                prev_d = px;
                run_d  = (is_same && !run_flush) ? run_inc : 6'd0;
            end
            // Accept implies any held beat drains this cycle.
            out_valid_d = beat_en;
            if (beat_en) begin
                out_data_d  = beat_data;
                out_bytes_d = beat_bytes;
                out_last_d  = in_last;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= PIXEL_RESET;
            run_q       <= 6'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            run_q       <= run_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_bytes_q <= out_bytes_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_bytes = out_bytes_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_qoi_encoder_stream.sv
// Self-checking bench: RGB encoder for ops and runs, RGBA encoder for alpha, backpressure, reset.
module tb_qoi_encoder_stream;

    typedef struct packed {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [7:0]  a;
        logic        last;
        logic        has_beat;
        logic [47:0] data;
        logic [2:0]  bytes;
    } stim_t;

    typedef struct packed {
        logic [47:0] data;
        logic [2:0]  bytes;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst3, in_valid3, in_ready3, last3, out_valid3, out_ready3, olast3;
    logic [7:0]  r3, g3, b3, a3;
    logic [47:0] data3;
    logic [2:0]  bytes3;

    logic        rst4, in_valid4, in_ready4, last4, out_valid4, out_ready4, olast4;
    logic [7:0]  r4, g4, b4, a4;
    logic [47:0] data4;
    logic [2:0]  bytes4;

    int checks = 0;
    int errors = 0;
    beat_t exp_q[$];

    qoi_encoder_stream #(
        .CHANNELS (3)
    ) u_rgb (
        .clk       (clk),
        .rst       (rst3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .in_r      (r3),
        .in_g      (g3),
        .in_b      (b3),
        .in_a      (a3),
        .in_last   (last3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_data  (data3),
        .out_bytes (bytes3),
        .out_last  (olast3)
    );

    qoi_encoder_stream #(
        .CHANNELS (4)
    ) u_rgba (
        .clk       (clk),
        .rst       (rst4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .in_r      (r4),
        .in_g      (g4),
        .in_b      (b4),
        .in_a      (a4),
        .in_last   (last4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_data  (data4),
        .out_bytes (bytes4),
        .out_last  (olast4)
    );

    function automatic stim_t mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                 input logic [7:0] a, input logic last, input logic has_beat,
                                 input logic [47:0] data, input logic [2:0] bytes);
        stim_t s;
        s.r = r; s.g = g; s.b = b; s.a = a;
        s.last = last; s.has_beat = has_beat; s.data = data; s.bytes = bytes;
        return s;
    endfunction

    task automatic test_reset();
        rst3 = 1'b1; rst4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst3 = 1'b0; rst4 = 1'b0;
        checks += 5;
        if (out_valid3 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid3); end
        if (data3 !== 48'h0) begin errors++; $display("FAIL reset_data got %h want 0", data3); end
        if (bytes3 !== 3'd0) begin errors++; $display("FAIL reset_bytes got %0d want 0", bytes3); end
        if (olast3 !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", olast3); end
        if (in_ready3 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready3); end
    endtask

    // Several one-image streams back to back: RUN, DIFF+LUMA, RGB, RGB+RGB+INDEX.
    task automatic test_ops();
        stim_t s[$];
        beat_t want;
        s.push_back(mk(8'd0, 8'd0, 8'd0, 8'd255, 1'b1, 1'b1, 48'hC0_0000000000, 3'd1));
        s.push_back(mk(8'd1, 8'd255, 8'd0, 8'd255, 1'b0, 1'b1, 48'h76_0000000000, 3'd1));
        // dg=16, dr-dg=4, db-dg=-2
        s.push_back(mk(8'd21, 8'd15, 8'd14, 8'd255, 1'b1, 1'b1, 48'hB0C6_00000000, 3'd2));
        s.push_back(mk(8'd200, 8'd0, 8'd0, 8'd255, 1'b1, 1'b1, 48'hFEC80000_0000, 3'd4));
        s.push_back(mk(8'd10, 8'd20, 8'd30, 8'd255, 1'b0, 1'b1, 48'hFE0A141E_0000, 3'd4));
        s.push_back(mk(8'd100, 8'd0, 8'd0, 8'd255, 1'b0, 1'b1, 48'hFE640000_0000, 3'd4));
        s.push_back(mk(8'd10, 8'd20, 8'd30, 8'd255, 1'b1, 1'b1, 48'h09_0000000000, 3'd1));
        for (int i = 0; i < s.size(); i++) begin
            r3 = s[i].r; g3 = s[i].g; b3 = s[i].b; a3 = s[i].a; last3 = s[i].last;
            in_valid3 = 1'b1;
            if (s[i].has_beat) exp_q.push_back(beat_t'{s[i].data, s[i].bytes, s[i].last});
            @(posedge clk);
            #1;
            checks++;
            if (out_valid3 !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL ops_valid px%0d got %b want %b", i, out_valid3, exp_q.size() != 0);
            end
            if (out_valid3 === 1'b1 && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({data3, bytes3, olast3} !== want) begin
                    errors++;
                    $display("FAIL ops_beat px%0d got %h/%0d/%b want %h/%0d/%b", i, data3, bytes3,
                             olast3, want.data, want.bytes, want.last);
                end
            end else begin
                exp_q.delete();
            end
        end
        in_valid3 = 1'b0;
    endtask

    // Run saturation, saturation coinciding with last, and a pending run ahead of an op.
    task automatic test_runs();
        stim_t s[$];
        beat_t want;
        for (int i = 0; i < 63; i++) begin
            s.push_back(mk(8'd0, 8'd0, 8'd0, 8'd255, i == 62, i >= 61,
                           (i == 61) ? 48'hFD_0000000000 : 48'hC0_0000000000, 3'd1));
        end
        for (int i = 0; i < 62; i++) begin
            s.push_back(mk(8'd0, 8'd0, 8'd0, 8'd255, i == 61, i == 61, 48'hFD_0000000000, 3'd1));
        end
        for (int i = 0; i < 3; i++) begin
            s.push_back(mk(8'd0, 8'd0, 8'd0, 8'd255, 1'b0, 1'b0, 48'h0, 3'd0));
        end
        s.push_back(mk(8'd200, 8'd0, 8'd0, 8'd255, 1'b1, 1'b1, 48'hC2FEC8000000, 3'd5));
        for (int i = 0; i < s.size(); i++) begin
            r3 = s[i].r; g3 = s[i].g; b3 = s[i].b; a3 = s[i].a; last3 = s[i].last;
            in_valid3 = 1'b1;
            if (s[i].has_beat) exp_q.push_back(beat_t'{s[i].data, s[i].bytes, s[i].last});
            @(posedge clk);
            #1;
            checks++;
            if (out_valid3 !== (exp_q.size() != 0)) begin
                errors++;
                $display("FAIL runs_valid px%0d got %b want %b", i, out_valid3, exp_q.size() != 0);
            end
            if (out_valid3 === 1'b1 && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if ({data3, bytes3, olast3} !== want) begin
                    errors++;
                    $display("FAIL runs_beat px%0d got %h/%0d/%b want %h/%0d/%b", i, data3, bytes3,
                             olast3, want.data, want.bytes, want.last);
                end
            end else begin
                exp_q.delete();
            end
        end
        in_valid3 = 1'b0;
    endtask

    // RGBA op, held beat under backpressure, then reset mid-image.
    task automatic test_back_to_back();
        beat_t want;
        exp_q.delete();
        r4 = 8'd0; g4 = 8'd0; b4 = 8'd0; a4 = 8'd128; last4 = 1'b0;
        in_valid4 = 1'b1; out_ready4 = 1'b0;
        exp_q.push_back(beat_t'{48'hFF0000008000, 3'd5, 1'b0});
        @(posedge clk);
        #1;
        want = exp_q.pop_front();
        checks++;
        if (out_valid4 !== 1'b1 || {data4, bytes4, olast4} !== want) begin
            errors++;
            $display("FAIL rgba_beat got %b %h/%0d/%b want 1 %h/%0d/%b", out_valid4, data4, bytes4,
                     olast4, want.data, want.bytes, want.last);
        end
        r4 = 8'd5; a4 = 8'd200;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks += 2;
            if (in_ready4 !== 1'b0) begin
                errors++;
                $display("FAIL hold_ready cyc%0d got %b want 0", i, in_ready4);
            end
            if (out_valid4 !== 1'b1 || {data4, bytes4, olast4} !== want) begin
                errors++;
                $display("FAIL hold_stable cyc%0d got %b %h/%0d want 1 %h/%0d", i, out_valid4,
                         data4, bytes4, want.data, want.bytes);
            end
        end
        in_valid4 = 1'b0;
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0 || data4 !== 48'h0) begin
            errors++;
            $display("FAIL midreset got %b %h want 0 0", out_valid4, data4);
        end
        r4 = 8'd0; g4 = 8'd0; b4 = 8'd0; a4 = 8'd255; last4 = 1'b1;
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        exp_q.push_back(beat_t'{48'hC0_0000000000, 3'd1, 1'b1});
        @(posedge clk);
        #1;
        in_valid4 = 1'b0; last4 = 1'b0;
        want = exp_q.pop_front();
        checks++;
        if (out_valid4 !== 1'b1 || {data4, bytes4, olast4} !== want) begin
            errors++;
            $display("FAIL post_reset_run got %b %h/%0d/%b want 1 %h/%0d/%b", out_valid4, data4,
                     bytes4, olast4, want.data, want.bytes, want.last);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid4 !== 1'b0) begin
            errors++;
            $display("FAIL drain got %b want 0", out_valid4);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        {in_valid3, last3, r3, g3, b3, a3} = '0;
        {in_valid4, last4, r4, g4, b4, a4} = '0;
        out_ready3 = 1'b1; out_ready4 = 1'b1;
        rst3 = 1'b1; rst4 = 1'b1;
        test_reset();
        test_ops();
        test_runs();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
